// File: rtl/sram_lsu_bridge.sv
// ---------------------------------------------------------------------------
// sram_lsu_bridge
//    Bridges a simple load/store request/response interface onto one
//    byte-masked port of a 32-bit-wide dual-port RAM.
//    Byte, half and word accesses are supported. Loads are sign- or
//    zero-extended. Out-of-range and illegal-size requests respond with an
//    error and never touch the RAM.
//
// Configuration macro:
//    LSU_MISALIGN_SPLIT_EN - when defined, accesses that straddle two words
//                            are performed as two RAM accesses (ACC2 state).
//                            When undefined, such accesses are errors and the
//                            second-access logic is not built.
//
// Ports:
//    clk, rst_n      - clock, asynchronous active-low reset
//    req_*           - request (valid/ready handshake, we, addr, size,
//                      unsigned, wdata)
//    rsp_*           - one-cycle response pulse with load data and error flag
//    ram_*           - RAM port (en, we, wem, addr, din, dout); ram_dout is
//                      valid the cycle after a read enable
// ---------------------------------------------------------------------------
module sram_lsu_bridge #(
   parameter int RAM_DEPTH = 1024
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic                         req_we,
   input  logic [31:0]                  req_addr,
   input  logic [1:0]                   req_size,
   input  logic                         req_unsigned,
   input  logic [31:0]                  req_wdata,
   output logic                         rsp_valid,
   output logic [31:0]                  rsp_rdata,
   output logic                         rsp_err,
   output logic                         ram_en,
   output logic                         ram_we,
   output logic [3:0]                   ram_wem,
   output logic [$clog2(RAM_DEPTH)-1:0] ram_addr,
   output logic [31:0]                  ram_din,
   input  logic [31:0]                  ram_dout
);

   localparam int AW = $clog2(RAM_DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC2 = 2'd1,
      WAIT = 2'd2,
      RSP  = 2'd3
   } state_t;

   // Lane mask of an access starting at lane 0.
   function automatic logic [3:0] lane_mask(input logic [1:0] size);
      logic [3:0] m;
      case (size)
         2'b00:   m = 4'b0001;
         2'b01:   m = 4'b0011;
         2'b10:   m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   // Shift the two-word window down to the access offset, truncate to the
   // access size and extend.
   function automatic logic [31:0] fmt_load(input logic [31:0] lo,
                                            input logic [31:0] hi,
                                            input logic [1:0]  off,
                                            input logic [1:0]  size,
                                            input logic        uns);
      logic [63:0] cat;
      logic [31:0] res;
      cat = {hi, lo} >> {off, 3'b000};
      case (size)
         2'b00:   res = uns ? {24'd0, cat[7:0]}  : {{24{cat[7]}},  cat[7:0]};
         2'b01:   res = uns ? {16'd0, cat[15:0]} : {{16{cat[15]}}, cat[15:0]};
         2'b10:   res = cat[31:0];
         default: res = 32'd0;
      endcase
      return res;
   endfunction

   state_t        state_q;
   logic [1:0]    off_q;
   logic [1:0]    size_q;
   logic          unsigned_q;
   logic          rsp_valid_q;
   logic          rsp_err_q;
   logic [31:0]   rsp_rdata_q;
`ifdef LSU_MISALIGN_SPLIT_EN
   logic          we_q;
   logic          split_q;
   logic [AW-1:0] waddr_q;
   logic [31:0]   wdata_q;
   logic [31:0]   first_q;
   logic [2:0]    rem_s;
   logic          last_s;
`endif

   logic [1:0]    off_s;
   logic [AW-1:0] word_s;
   logic [3:0]    mask_s;
   logic          mis_s;
   logic          oob_s;
   logic          err_s;

   // Ready only in IDLE and never while reset is applied.
   assign req_ready = rst_n && (state_q == IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

   // Decode the incoming request fields and classify errors.
   always_comb begin
      off_s  = req_addr[1:0];
      word_s = req_addr[AW+1:2];
      mask_s = lane_mask(req_size);
      mis_s  = ((req_size == 2'b01) && (off_s == 2'b11)) ||
               ((req_size == 2'b10) && (off_s != 2'b00));
      oob_s  = ({2'b00, req_addr} >= (34'(RAM_DEPTH) << 2));
`ifdef LSU_MISALIGN_SPLIT_EN
      // A split whose second word would fall off the end of the RAM.
      last_s = (({1'b0, word_s} + {{AW{1'b0}}, 1'b1}) == (AW+1)'(RAM_DEPTH));
      err_s  = (req_size == 2'b11) || oob_s || (mis_s && last_s);
`else
      err_s  = (req_size == 2'b11) || oob_s || mis_s;
`endif
   end

   // RAM port drive: first access straight from the request, second access
   // from the registered copy.
   always_comb begin
      ram_en   = 1'b0;
      ram_we   = 1'b0;
      ram_wem  = 4'b0000;
      ram_addr = '0;
      ram_din  = 32'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
      rem_s    = 3'd4 - {1'b0, off_q};
`endif
      case (state_q)
         IDLE: begin
            if (req_ready && req_valid && !err_s) begin
               ram_en   = 1'b1;
               ram_we   = req_we;
               ram_addr = word_s;
               ram_wem  = req_we ? (mask_s << off_s) : 4'b0000;
               ram_din  = req_wdata << {off_s, 3'b000};
            end else begin
               ram_en   = 1'b0;
            end
         end
`ifdef LSU_MISALIGN_SPLIT_EN
         ACC2: begin
            ram_en   = 1'b1;
            ram_we   = we_q;
            ram_addr = waddr_q + {{(AW-1){1'b0}}, 1'b1};
            ram_wem  = we_q ? (lane_mask(size_q) >> rem_s) : 4'b0000;
            ram_din  = wdata_q >> {rem_s, 3'b000};
         end
`endif
         default: begin
            ram_en   = 1'b0;
         end
      endcase
   end

   // Control FSM with registered response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         off_q       <= 2'd0;
         size_q      <= 2'd0;
         unsigned_q  <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
         we_q        <= 1'b0;
         split_q     <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= 32'd0;
         first_q     <= 32'd0;
`endif
      end else begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'd0;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  off_q      <= off_s;
                  size_q     <= req_size;
                  unsigned_q <= req_unsigned;
`ifdef LSU_MISALIGN_SPLIT_EN
                  we_q       <= req_we;
                  split_q    <= mis_s && !err_s;
                  waddr_q    <= word_s;
                  wdata_q    <= req_wdata;
`endif
                  if (err_s) begin
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     state_q     <= RSP;
`ifdef LSU_MISALIGN_SPLIT_EN
                  end else if (mis_s) begin
                     state_q     <= ACC2;
`endif
                  end else if (req_we) begin
                     rsp_valid_q <= 1'b1;
                     state_q     <= RSP;
                  end else begin
                     state_q     <= WAIT;
                  end
               end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ACC2: begin
               // ram_dout holds the first word of a split load here.
               first_q <= ram_dout;
               if (we_q) begin
                  rsp_valid_q <= 1'b1;
                  state_q     <= RSP;
               end else begin
                  state_q     <= WAIT;
               end
            end
`endif
            WAIT: begin
               rsp_valid_q <= 1'b1;
`ifdef LSU_MISALIGN_SPLIT_EN
               if (split_q) begin
                  rsp_rdata_q <= fmt_load(first_q, ram_dout, off_q, size_q, unsigned_q);
               end else begin
                  rsp_rdata_q <= fmt_load(ram_dout, 32'd0, off_q, size_q, unsigned_q);
               end
`else
               rsp_rdata_q <= fmt_load(ram_dout, 32'd0, off_q, size_q, unsigned_q);
`endif
               state_q     <= RSP;
            end
            RSP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_lsu_bridge.sv
module tb_sram_lsu_bridge;

   localparam int DEPTH = 1024;
   localparam int AW    = $clog2(DEPTH);

   logic          clk;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [31:0]   req_addr;
   logic [1:0]    req_size;
   logic          req_unsigned;
   logic [31:0]   req_wdata;
   logic          rsp_valid;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   logic          ram_en;
   logic          ram_we;
   logic [3:0]    ram_wem;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_din;
   logic [31:0]   ram_dout;

   typedef struct {
      logic [31:0] d;
      logic        e;
      int          lat;
      int          t0;
      string       tag;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          ram_en_cnt = 0;
   int          last_acc = 0;
   int          prev_acc = 0;
   int          en_before = 0;
   logic [31:0] mem [DEPTH];

   sram_lsu_bridge #(.RAM_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .ram_en(ram_en), .ram_we(ram_we), .ram_wem(ram_wem), .ram_addr(ram_addr),
      .ram_din(ram_din), .ram_dout(ram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ram_en) ram_en_cnt <= ram_en_cnt + 1;
   end

   // Byte-masked RAM model with one-cycle read latency.
   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'd0;
      ram_dout = 32'd0;
   end
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) begin
            for (int b = 0; b < 4; b++)
               if (ram_wem[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
         end
         ram_dout <= mem[ram_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Response scoreboard.
   always @(negedge clk) begin
      if (rst_n && rsp_valid) begin
         if (sb_q.size() == 0) begin
            checks++;
            assert (sb_q.size() != 0) else begin
               errors++;
               $error("FAIL unexpected_rsp observed=rsp_valid expected=no_rsp");
            end
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk({e.tag, "_rdata"}, rsp_rdata, e.d);
            chk({e.tag, "_err"}, {31'd0, rsp_err}, {31'd0, e.e});
            chk({e.tag, "_lat"}, cyc - e.t0, e.lat);
         end
      end
   end

   task automatic send(input string tag, input logic we, input logic [31:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wd,
                       input logic [31:0] ed, input logic ee, input int lat);
      int g;
      g = 0;
      while (!req_ready && g < 20) begin
         @(negedge clk);
         g++;
      end
      chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
      req_valid    = 1'b1;
      req_we       = we;
      req_addr     = addr;
      req_size     = size;
      req_unsigned = uns;
      req_wdata    = wd;
      sb_q.push_back('{ed, ee, lat, cyc, tag});
      prev_acc = last_acc;
      last_acc = cyc;
      #1;
   endtask

   // Advance one cycle and scramble the request bus.
   task automatic step();
      @(negedge clk);
      req_valid    = 1'b0;
      req_we       = 1'($urandom);
      req_addr     = $urandom;
      req_size     = 2'($urandom);
      req_unsigned = 1'($urandom);
      req_wdata    = $urandom;
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int g;
      g = 0;
      while (sb_q.size() != 0 && g < 30) begin
         @(negedge clk);
         g++;
      end
      chk({tag, "_drained"}, sb_q.size(), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
      req_size = 2'b00; req_unsigned = 1'b0; req_wdata = 32'd0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
      chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
      chk("rst_ram_wem", {28'd0, ram_wem}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel_ready", {31'd0, req_ready}, 32'd1);

      // Aligned word store then load (0x8000_0004 would be out of range).
      send("st_w4", 1'b1, 32'h4, 2'b10, 1'b0, 32'hDEADBEEF, 32'd0, 1'b0, 1);
      chk("st_w4_en", {31'd0, ram_en}, 32'd1);
      chk("st_w4_we", {31'd0, ram_we}, 32'd1);
      chk("st_w4_wem", {28'd0, ram_wem}, 32'hF);
      chk("st_w4_addr", 32'(ram_addr), 32'd1);
      chk("st_w4_din", ram_din, 32'hDEADBEEF);
      step(); wait_idle("st_w4");
      send("ld_w4", 1'b0, 32'h4, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 2);
      chk("ld_w4_wem", {28'd0, ram_wem}, 32'h0);
      chk("ld_w4_we", {31'd0, ram_we}, 32'd0);
      step(); wait_idle("ld_w4");

      // Byte/half loads with sign and zero extension; word 1 = 0x80ABCDEF.
      send("st_w4b", 1'b1, 32'h4, 2'b10, 1'b0, 32'h80ABCDEF, 32'd0, 1'b0, 1);
      step(); wait_idle("st_w4b");
      send("ld_b7s", 1'b0, 32'h7, 2'b00, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0, 2);
      // Junk request while busy must be ignored.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h4; req_size = 2'b10; req_wdata = 32'h0;
      #1;
      chk("busy_ready", {31'd0, req_ready}, 32'd0);
      chk("busy_ram_en", {31'd0, ram_en}, 32'd0);
      step(); wait_idle("ld_b7s");
      send("ld_b7u", 1'b0, 32'h7, 2'b00, 1'b1, 32'h0, 32'h00000080, 1'b0, 2);
      step(); wait_idle("ld_b7u");
      send("ld_h6s", 1'b0, 32'h6, 2'b01, 1'b0, 32'h0, 32'hFFFF80AB, 1'b0, 2);
      step(); wait_idle("ld_h6s");
      send("ld_h4u", 1'b0, 32'h4, 2'b01, 1'b1, 32'h0, 32'h0000CDEF, 1'b0, 2);
      step(); wait_idle("ld_h4u");
      send("ld_b5s", 1'b0, 32'h5, 2'b00, 1'b0, 32'h0, 32'hFFFFFFCD, 1'b0, 2);
      step(); wait_idle("ld_b5s");

      // Sub-word stores into word 2.
      send("st_b9", 1'b1, 32'h9, 2'b00, 1'b0, 32'h123456AA, 32'd0, 1'b0, 1);
      chk("st_b9_wem", {28'd0, ram_wem}, 32'h2);
      chk("st_b9_din", ram_din, 32'h3456AA00);
      step(); wait_idle("st_b9");
      send("st_hA", 1'b1, 32'hA, 2'b01, 1'b0, 32'h0000BEEF, 32'd0, 1'b0, 1);
      chk("st_hA_wem", {28'd0, ram_wem}, 32'hC);
      chk("st_hA_din", ram_din, 32'hBEEF0000);
      step(); wait_idle("st_hA");
      send("ld_w8", 1'b0, 32'h8, 2'b10, 1'b0, 32'h0, 32'hBEEFAA00, 1'b0, 2);
      step(); wait_idle("ld_w8");

      // Errors never enable the RAM.
      en_before = ram_en_cnt;
      send("err_oob", 1'b0, 32'(4*DEPTH), 2'b10, 1'b0, 32'h0, 32'd0, 1'b1, 1);
      step(); wait_idle("err_oob");
      send("err_sz", 1'b1, 32'h10, 2'b11, 1'b0, 32'h55, 32'd0, 1'b1, 1);
      step(); wait_idle("err_sz");
      send("err_hi", 1'b1, 32'h80000004, 2'b10, 1'b0, 32'h1, 32'd0, 1'b1, 1);
      step(); wait_idle("err_hi");
      send("err_last", 1'b0, 32'(4*DEPTH-2), 2'b10, 1'b0, 32'h0, 32'd0, 1'b1, 1);
      step(); wait_idle("err_last");
      chk("err_no_ram_en", ram_en_cnt - en_before, 32'd0);

      // Back-to-back aligned stores accepted every two cycles.
      send("bb_a", 1'b1, 32'h20, 2'b10, 1'b0, 32'h01020304, 32'd0, 1'b0, 1);
      step();
      send("bb_b", 1'b1, 32'h24, 2'b10, 1'b0, 32'h05060708, 32'd0, 1'b0, 1);
      chk("bb_spacing", last_acc - prev_acc, 32'd2);
      step(); wait_idle("bb");
      send("ld_20", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 32'h01020304, 1'b0, 2);
      step(); wait_idle("ld_20");
      send("ld_24", 1'b0, 32'h24, 2'b10, 1'b0, 32'h0, 32'h05060708, 1'b0, 2);
      step(); wait_idle("ld_24");

`ifdef LSU_MISALIGN_SPLIT_EN
      send("sp_st", 1'b1, 32'h2, 2'b10, 1'b0, 32'h11223344, 32'd0, 1'b0, 2);
      chk("sp_st1_wem", {28'd0, ram_wem}, 32'hC);
      chk("sp_st1_addr", 32'(ram_addr), 32'd0);
      chk("sp_st1_din", ram_din, 32'h33440000);
      step();
      chk("sp_st2_en", {31'd0, ram_en}, 32'd1);
      chk("sp_st2_wem", {28'd0, ram_wem}, 32'h3);
      chk("sp_st2_addr", 32'(ram_addr), 32'd1);
      chk("sp_st2_din", ram_din, 32'h00001122);
      wait_idle("sp_st");
      send("sp_ld", 1'b0, 32'h2, 2'b10, 1'b0, 32'h0, 32'h11223344, 1'b0, 3);
      step(); wait_idle("sp_ld");
      send("sp_w0", 1'b0, 32'h0, 2'b10, 1'b0, 32'h0, 32'h33440000, 1'b0, 2);
      step(); wait_idle("sp_w0");
      send("sp_w1", 1'b0, 32'h4, 2'b10, 1'b0, 32'h0, 32'h80AB1122, 1'b0, 2);
      step(); wait_idle("sp_w1");
      send("sp_h3", 1'b0, 32'h3, 2'b01, 1'b1, 32'h0, 32'h00002233, 1'b0, 3);
      step(); wait_idle("sp_h3");
`else
      en_before = ram_en_cnt;
      send("mis_st", 1'b1, 32'h2, 2'b10, 1'b0, 32'h11223344, 32'd0, 1'b1, 1);
      step(); wait_idle("mis_st");
      send("mis_h3", 1'b0, 32'h3, 2'b01, 1'b0, 32'h0, 32'd0, 1'b1, 1);
      step(); wait_idle("mis_h3");
      chk("mis_no_ram_en", ram_en_cnt - en_before, 32'd0);
      send("mis_w1", 1'b0, 32'h4, 2'b10, 1'b0, 32'h0, 32'h80ABCDEF, 1'b0, 2);
      step(); wait_idle("mis_w1");
`endif

      // Reset at T+1 of a load abandons it.
`ifdef LSU_MISALIGN_SPLIT_EN
      send("rst_ld", 1'b0, 32'h2, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 3);
`else
      send("rst_ld", 1'b0, 32'h4, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 2);
`endif
      step();
      rst_n = 1'b0;
      sb_q.delete();
      #1;
      chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
      chk("mid_rst_ram_en", {31'd0, ram_en}, 32'd0);
      repeat (2) @(negedge clk);
      chk("mid_rst_rsp", {31'd0, rsp_valid}, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
      repeat (3) @(negedge clk);
`ifdef LSU_MISALIGN_SPLIT_EN
      send("post_ld", 1'b0, 32'h4, 2'b10, 1'b0, 32'h0, 32'h80AB1122, 1'b0, 2);
`else
      send("post_ld", 1'b0, 32'h4, 2'b10, 1'b0, 32'h0, 32'h80ABCDEF, 1'b0, 2);
`endif
      step(); wait_idle("post_ld");
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
